phys_free_list: RTL and testbench
=================================

Name: phys_free_list

Overview:
- Circular FIFO of free physical register numbers for the rename stage.
- Hands out destination pregs to rename at the head pointer.
- Takes back each committed instruction's previous mapping (commit_prd_old) at the tail pointer.
- Exposes its head pointer as the freelist checkpoint stored with each branch; on mispredict recovery it rewinds the head to the checkpointed value, reclaiming every preg allocated on the wrong path.

Parameters:
- PHYS_REG_BITS, 6: width of a preg number and of the list pointers; NUM_PHYS = 2**PHYS_REG_BITS = list depth.
- NUM_ARCH_REGS, 32: architectural registers; pregs 0..NUM_ARCH_REGS-1 are the initial mappings and never start free.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  rename consumes alloc_prd this cycle
- alloc_valid  out  1  list non-empty, alloc_prd is meaningful
- alloc_prd  out  PHYS_REG_BITS  preg at head
- free_en  in  1  commit returns a preg (commit_en && commit_reg_write)
- free_prd  in  PHYS_REG_BITS  preg returned (commit_prd_old)
- restore_en  in  1  mispredict recovery
- restore_head_ptr  in  PHYS_REG_BITS  checkpointed head (restore_freelist_ptr)
- ckpt_head_ptr  out  PHYS_REG_BITS  current head, captured by rename as checkpoint_freelist_ptr
- free_count  out  PHYS_REG_BITS  number of free pregs held
- empty  out  1  free_count == 0
- overflow_err  out  1  sticky: a free was dropped because the list was at capacity

Behaviour:
- Storage: NUM_PHYS entries of PHYS_REG_BITS each, plus head and tail pointers of PHYS_REG_BITS each.
- Pointers wrap modulo NUM_PHYS; arithmetic is natural-width truncation.
- Capacity CAP = NUM_PHYS - NUM_ARCH_REGS (32 by default). free_count never exceeds CAP, so tail - head (mod NUM_PHYS) is unambiguous.
- Reset (async, rst high) sets:
  - entry[i] = NUM_ARCH_REGS + i for i in 0..CAP-1; remaining entries = 0
  - head = 0, tail = CAP
  - overflow_err = 0
  - Resulting outputs: alloc_valid = 1, alloc_prd = NUM_ARCH_REGS, ckpt_head_ptr = 0, free_count = CAP, empty = 0.
  - Reset mid-operation discards all state immediately.
- Combinational outputs:
  - alloc_prd = entry[head]
  - alloc_valid = !empty
  - ckpt_head_ptr = head
  - free_count = tail - head
  - empty = (free_count == 0)
- Allocation:
  - alloc_req && !empty: head <= head+1 at the next edge.
  - alloc_req while empty: ignored, head unchanged. Rename must stall on !alloc_valid.
- Free:
  - free_en && free_prd != 0 && free_count < CAP: entry[tail] <= free_prd, tail <= tail+1.
  - free_prd == 0 (hardwired x0 mapping): ignored, no error.
  - free_en at capacity: ignored, overflow_err <= 1 (cleared only by reset).
- Restore:
  - restore_en: head <= restore_head_ptr. Any alloc_req in the same cycle is ignored (restore has priority).
  - A same-cycle free still writes at the old tail and advances tail. Resulting free_count = new tail - restore_head_ptr.
  - restore_head_ptr is used as given, with no range check; the ROB guarantees it is a prior head value.
- Simultaneous alloc and free, with list non-empty and free_count < CAP: both occur, free_count unchanged.
  - When empty, alloc is ignored even if a free arrives that cycle. The freed preg becomes visible at alloc_prd the next cycle; there is no bypass.
- Latency: allocation, free and restore all take effect on the next edge. All outputs are derived combinationally from registered state.

Test Plan:
- Reset, then 32 back-to-back alloc_req → alloc_prd sequence 32,33,…,63; then empty=1, alloc_valid=0, free_count=0; 33rd alloc_req leaves head at 32.
- From empty, free_en with free_prd=5 → next cycle alloc_valid=1, alloc_prd=5, free_count=1; with free_prd=0 instead → still empty.
- After reset, alloc 3 (32,33,34) and free_prd=40 in the same cycle as the third alloc → free_count=30, tail=33, entry[32]=40.
- Checkpoint: after 2 allocs ckpt_head_ptr=2; alloc 5 more (head=7); restore_en with restore_head_ptr=2 plus simultaneous alloc_req → head=2, alloc_prd=34, free_count=30.
- Wrap: cycle allocs and frees until tail crosses 63→0 → entries read back in FIFO order, and free_count is correct across the wrap.
- Free at full (no allocs after reset), free_prd=7 → tail stays 32, free_count=32, overflow_err=1 and it persists until rst is asserted; assert rst mid-burst → state matches reset values immediately.

Source files
------------

// File: rtl/phys_free_list.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// phys_free_list
//
// Circular FIFO of free physical register numbers used by the rename stage.
// Rename takes destination pregs from the head; commit returns each
// instruction's previous mapping at the tail. The head pointer doubles as
// the free-list checkpoint stored with every branch. On mispredict recovery
// the head is rewound to that checkpoint, which reclaims every preg handed
// out on the wrong path without touching the stored entries.
//
// Parameters
//   PHYS_REG_BITS    width of a preg number and of the list pointers
//   NUM_ARCH_REGS    pregs 0..NUM_ARCH_REGS-1 hold the initial mappings
//                    and never start out free
//
// Ports
//   clk               clock
//   rst               asynchronous, active-high reset
//   alloc_req         rename consumes alloc_prd this cycle
//   alloc_valid       list non-empty, alloc_prd is meaningful
//   alloc_prd         preg at the head
//   free_en           commit returns a preg this cycle
//   free_prd          preg being returned (previous mapping)
//   restore_en        mispredict recovery, rewind the head
//   restore_head_ptr  checkpointed head to rewind to
//   ckpt_head_ptr     current head, captured by rename as a checkpoint
//   free_count        number of free pregs held
//   empty             free_count == 0
//   overflow_err      sticky: a free was dropped because the list was full
// ---------------------------------------------------------------------------
module phys_free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic                     alloc_valid,
  output logic [PHYS_REG_BITS-1:0] alloc_prd,
  input  logic                     free_en,
  input  logic [PHYS_REG_BITS-1:0] free_prd,
  input  logic                     restore_en,
  input  logic [PHYS_REG_BITS-1:0] restore_head_ptr,
  output logic [PHYS_REG_BITS-1:0] ckpt_head_ptr,
  output logic [PHYS_REG_BITS-1:0] free_count,
  output logic                     empty,
  output logic                     overflow_err
);

  localparam int NUM_PHYS = 1 << PHYS_REG_BITS;
  localparam int CAP      = NUM_PHYS - NUM_ARCH_REGS;

  localparam logic [PHYS_REG_BITS-1:0] CAP_W = PHYS_REG_BITS'(CAP);
  localparam logic [PHYS_REG_BITS-1:0] ONE_W = PHYS_REG_BITS'(1);

  logic [PHYS_REG_BITS-1:0] r_entry [NUM_PHYS];
  logic [PHYS_REG_BITS-1:0] r_head;
  logic [PHYS_REG_BITS-1:0] r_tail;
  logic                     r_overflow;

  logic [PHYS_REG_BITS-1:0] w_count;
  logic                     w_empty;
  logic                     w_below_cap;
  logic                     w_free_nonzero;
  logic                     w_free_ok;
  logic                     w_free_drop;
  logic                     w_alloc_fire;

  // The list never holds more than CAP entries, so the modular distance
  // from head to tail is always the true occupancy, including across the
  // pointer wrap from NUM_PHYS-1 back to 0.
  assign w_count     = r_tail - r_head;
  assign w_empty     = (w_count == '0);
  assign w_below_cap = (w_count < CAP_W);

  // Preg 0 is the hardwired x0 mapping; returning it is a no-op rather
  // than an error, so it is filtered out before the capacity check.
  assign w_free_nonzero = free_en && (free_prd != '0);
  assign w_free_ok      = w_free_nonzero && w_below_cap;
  assign w_free_drop    = w_free_nonzero && !w_below_cap;

  // Restore owns the head in its cycle, so a same-cycle allocation is
  // discarded. An empty list also swallows the request even if a free
  // lands this cycle: the freed preg only shows up at the head next cycle.
  assign w_alloc_fire = alloc_req && !w_empty && !restore_en;

  // Head, tail and the sticky overflow flag. Restore rewinds the head but
  // leaves the tail alone, so a free in the same cycle still lands at the
  // old tail and is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= CAP_W;
      r_overflow <= 1'b0;
    end else begin
      if (restore_en) begin
        r_head <= restore_head_ptr;
      end else if (w_alloc_fire) begin
        r_head <= r_head + ONE_W;
      end
      if (w_free_ok) begin
        r_tail <= r_tail + ONE_W;
      end
      if (w_free_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage. Reset preloads the first CAP slots with the pregs that
  // are not initial architectural mappings; the remaining slots are filled
  // by commit as the tail advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        r_entry[i] <= (i < CAP) ? PHYS_REG_BITS'(NUM_ARCH_REGS + i) : '0;
      end
    end else if (w_free_ok) begin
      r_entry[r_tail] <= free_prd;
    end
  end

  assign alloc_prd     = r_entry[r_head];
  assign alloc_valid   = !w_empty;
  assign ckpt_head_ptr = r_head;
  assign free_count    = w_count;
  assign empty         = w_empty;
  assign overflow_err  = r_overflow;

endmodule

// File: tb/tb_phys_free_list.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_phys_free_list
//
// Directed bench for phys_free_list with the default parameters
// (64 pregs, 32 architectural). Each vector holds the inputs for one cycle
// and the outputs expected just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       allocReq;
  logic       allocValid;
  logic [5:0] allocPrd;
  logic       freeEn;
  logic [5:0] freePrd;
  logic       restoreEn;
  logic [5:0] restoreHeadPtr;
  logic [5:0] ckptHeadPtr;
  logic [5:0] freeCount;
  logic       emptyOut;
  logic       overflowErr;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    logic       allocReq;
    logic       freeEn;
    logic [5:0] freePrd;
    logic       restoreEn;
    logic [5:0] restorePtr;
    logic       expValid;
    logic [5:0] expPrd;
    logic [5:0] expCkpt;
    logic [5:0] expCount;
    logic       expEmpty;
    logic       expOvf;
  } vec_t;

  phys_free_list #(
    .PHYS_REG_BITS (6),
    .NUM_ARCH_REGS (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (allocReq),
    .alloc_valid      (allocValid),
    .alloc_prd        (allocPrd),
    .free_en          (freeEn),
    .free_prd         (freePrd),
    .restore_en       (restoreEn),
    .restore_head_ptr (restoreHeadPtr),
    .ckpt_head_ptr    (ckptHeadPtr),
    .free_count       (freeCount),
    .empty            (emptyOut),
    .overflow_err     (overflowErr)
  );

  always #5 clk = ~clk;

  // Safety net so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic a, input logic f, input logic [5:0] fp,
                              input logic r, input logic [5:0] rp,
                              input logic ev, input logic [5:0] ep,
                              input logic [5:0] ec, input logic [5:0] en,
                              input logic ee, input logic eo);
    vec_t v;
    v.allocReq   = a;
    v.freeEn     = f;
    v.freePrd    = fp;
    v.restoreEn  = r;
    v.restorePtr = rp;
    v.expValid   = ev;
    v.expPrd     = ep;
    v.expCkpt    = ec;
    v.expCount   = en;
    v.expEmpty   = ee;
    v.expOvf     = eo;
    return v;
  endfunction

  task automatic cmpField(input string name, input string field,
                          input logic [5:0] got, input logic [5:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    vectorsApplied++;
    cmpField(name, "alloc_valid",   6'(allocValid),  6'(v.expValid));
    cmpField(name, "alloc_prd",     allocPrd,        v.expPrd);
    cmpField(name, "ckpt_head_ptr", ckptHeadPtr,     v.expCkpt);
    cmpField(name, "free_count",    freeCount,       v.expCount);
    cmpField(name, "empty",         6'(emptyOut),    6'(v.expEmpty));
    cmpField(name, "overflow_err",  6'(overflowErr), 6'(v.expOvf));
  endtask

  task automatic idleInputs();
    allocReq       = 1'b0;
    freeEn         = 1'b0;
    freePrd        = '0;
    restoreEn      = 1'b0;
    restoreHeadPtr = '0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then release them.
  task automatic applyStimulus(input vec_t v);
    allocReq       = v.allocReq;
    freeEn         = v.freeEn;
    freePrd        = v.freePrd;
    restoreEn      = v.restoreEn;
    restoreHeadPtr = v.restorePtr;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t resetVec;
    vec_t v;
    int   q[$];
    logic [5:0] headM;

    resetVec = mk(0, 0, 0, 0, 0, 1, 6'd32, 6'd0, 6'd32, 0, 0);

    // Main table: drain the list, then exercise frees into an empty list.
    for (int k = 1; k <= 31; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6'(32 + k), 6'(k), 6'(32 - k), 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'd0, 6'd32, 6'd0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'd0, 6'd32, 6'd0, 1, 0));
    tbl.push_back(mk(0, 1, 6'd0, 0, 0, 0, 6'd0, 6'd32, 6'd0, 1, 0));
    tbl.push_back(mk(0, 1, 6'd5, 0, 0, 1, 6'd5, 6'd32, 6'd1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'd0, 6'd33, 6'd0, 1, 0));
    tbl.push_back(mk(1, 1, 6'd9, 0, 0, 1, 6'd9, 6'd33, 6'd1, 0, 0));
    tbl.push_back(mk(0, 1, 6'd7, 0, 0, 1, 6'd9, 6'd33, 6'd2, 0, 0));
    tbl.push_back(mk(1, 1, 6'd11, 0, 0, 1, 6'd7, 6'd34, 6'd2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6'd11, 6'd35, 6'd1, 0, 0));

    $display("[TB] start");
    doReset();
    checkOutput("resetState", resetVec);
    foreach (tbl[i]) runVec($sformatf("tbl%0d", i), tbl[i]);

    // Alloc and free in the same cycle; the freed preg must come out after
    // the remaining preloaded pregs.
    doReset();
    runVec("simA1", mk(1, 0, 0, 0, 0, 1, 6'd33, 6'd1, 6'd31, 0, 0));
    runVec("simA2", mk(1, 0, 0, 0, 0, 1, 6'd34, 6'd2, 6'd30, 0, 0));
    runVec("simA3", mk(1, 1, 6'd40, 0, 0, 1, 6'd35, 6'd3, 6'd30, 0, 0));
    for (int k = 4; k <= 32; k++)
      runVec($sformatf("simDrain%0d", k),
             mk(1, 0, 0, 0, 0, 1, (k < 32) ? 6'(32 + k) : 6'd40, 6'(k), 6'(33 - k), 0, 0));

    // Checkpoint and restore, including restore with a same-cycle free.
    doReset();
    runVec("ckA1", mk(1, 0, 0, 0, 0, 1, 6'd33, 6'd1, 6'd31, 0, 0));
    runVec("ckA2", mk(1, 0, 0, 0, 0, 1, 6'd34, 6'd2, 6'd30, 0, 0));
    for (int k = 3; k <= 7; k++)
      runVec($sformatf("ckWrong%0d", k), mk(1, 0, 0, 0, 0, 1, 6'(32 + k), 6'(k), 6'(32 - k), 0, 0));
    runVec("restoreAlloc", mk(1, 0, 0, 1, 6'd2, 1, 6'd34, 6'd2, 6'd30, 0, 0));
    for (int k = 3; k <= 5; k++)
      runVec($sformatf("ckAgain%0d", k), mk(1, 0, 0, 0, 0, 1, 6'(32 + k), 6'(k), 6'(32 - k), 0, 0));
    runVec("restoreFree", mk(0, 1, 6'd50, 1, 6'd2, 1, 6'd34, 6'd2, 6'd31, 0, 0));
    for (int k = 3; k <= 32; k++)
      runVec($sformatf("ckDrain%0d", k),
             mk(1, 0, 0, 0, 0, 1, (k < 32) ? 6'(32 + k) : 6'd50, 6'(k), 6'(33 - k), 0, 0));

    // Pointer wrap: steady alloc+free pushes the tail past 63 back to 0.
    doReset();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    headM = 6'd0;
    void'(q.pop_front());
    headM = headM + 6'd1;
    runVec("wrapFirst", mk(1, 0, 0, 0, 0, 1, 6'(q[0]), headM, 6'(q.size()), 0, 0));
    for (int j = 0; j < 40; j++) begin
      void'(q.pop_front());
      q.push_back(j + 1);
      headM = headM + 6'd1;
      runVec($sformatf("wrapCycle%0d", j),
             mk(1, 1, 6'(j + 1), 0, 0, 1, 6'(q[0]), headM, 6'(q.size()), 0, 0));
    end
    for (int j = 0; j < 30; j++) begin
      void'(q.pop_front());
      headM = headM + 6'd1;
      runVec($sformatf("wrapDrain%0d", j),
             mk(1, 0, 0, 0, 0, 1, 6'(q[0]), headM, 6'(q.size()), 0, 0));
    end

    // Free at capacity: dropped, sticky error that survives until reset.
    doReset();
    runVec("ovfFree", mk(0, 1, 6'd7, 0, 0, 1, 6'd32, 6'd0, 6'd32, 0, 1));
    for (int k = 0; k < 3; k++)
      runVec($sformatf("ovfHold%0d", k), mk(0, 0, 0, 0, 0, 1, 6'd32, 6'd0, 6'd32, 0, 1));
    runVec("ovfAlloc", mk(1, 0, 0, 0, 0, 1, 6'd33, 6'd1, 6'd31, 0, 1));

    // Asynchronous reset in the middle of an alloc/free burst.
    allocReq = 1'b1;
    freeEn   = 1'b1;
    freePrd  = 6'd9;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("midReset", resetVec);
    @(posedge clk);
    #1;
    idleInputs();
    rst = 1'b0;
    checkOutput("postReset", resetVec);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
